// File: rtl/z0_cpu_pkg.sv
// Shared z0 CPU definitions: default widths, opcodes and the commit-hub state encoding.
package z0_cpu_pkg;

   localparam int DATA_W_DEF  = 16;
   localparam int PC_W_DEF    = 16;
   localparam int OPC_W_DEF   = 8;
   localparam int INSTR_W_DEF = 16;

   localparam logic [7:0] OP_MOVE = 8'h01;
   localparam logic [7:0] OP_LOAD = 8'h02;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_REQ  = 2'd1,
      LOAD_WAIT = 2'd2,
      HALT      = 2'd3
   } hub_state_t;

endpackage

// File: rtl/z0_hub_load_ctrl.sv
// Memory-read handshake for LOAD: holds the request until accepted, then waits for the
// response. done/data are combinational so the hub retires on the response edge.
//
// state     | meaning
// IDLE      | no load in flight
// LOAD_REQ  | mem_req_valid high, address held until mem_req_ready
// LOAD_WAIT | request accepted, waiting for mem_rsp_valid
module z0_hub_load_ctrl
   import z0_cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] addr,
   output logic              done,
   output logic [DATA_W-1:0] data,
   output hub_state_t        state,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [DATA_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state         <= LOAD_REQ;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= addr;
               end
            end
            LOAD_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  // a response in the accept cycle completes the load immediately
                  state         <= mem_rsp_valid ? IDLE : LOAD_WAIT;
               end
            end
            LOAD_WAIT: begin
               if (mem_rsp_valid) state <= IDLE;
            end
            default: begin
               state         <= IDLE;
               mem_req_valid <= 1'b0;
            end
         endcase
      end
   end

   assign done = ((state == LOAD_REQ) && mem_req_ready && mem_rsp_valid)
              || ((state == LOAD_WAIT) && mem_rsp_valid);
   assign data = mem_rsp_data;

endmodule

// File: rtl/z0_commit_hub.sv
// z0 commit hub: owns X/Y/MAR/MDR/PC and retires MOVE, LOAD and other opcodes one at a time.
// Optional macro Z0_HUB_ILLEGAL_TRAP_EN: unknown opcodes trap to HALT instead of acting as NOP.
module z0_commit_hub
   import z0_cpu_pkg::*;
#(
   parameter int                 DATA_W   = DATA_W_DEF,
   parameter int                 PC_W     = PC_W_DEF,
   parameter int                 OPC_W    = OPC_W_DEF,
   parameter int                 INSTR_W  = INSTR_W_DEF,
   parameter logic [PC_W-1:0]    PC_RESET = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instruction,
   input  logic [DATA_W-1:0]  mov_x,
   input  logic [DATA_W-1:0]  mov_y,
   input  logic [DATA_W-1:0]  mov_mar,
   input  logic [DATA_W-1:0]  mov_mdr,
   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic [DATA_W-1:0]  mem_req_addr,
   input  logic               mem_rsp_valid,
   input  logic [DATA_W-1:0]  mem_rsp_data,
   output logic [DATA_W-1:0]  reg_x,
   output logic [DATA_W-1:0]  reg_y,
   output logic [DATA_W-1:0]  reg_mar,
   output logic [DATA_W-1:0]  reg_mdr,
   output logic [PC_W-1:0]    pc,
   output logic               commit,
   output logic               illegal_op
);

   logic [OPC_W-1:0]  opcode;
   logic              instr_unused;
   logic              accept;
   logic              is_move;
   logic              is_load;
   logic              ld_done;
   logic [DATA_W-1:0] ld_data;
   hub_state_t        ld_state;
   hub_state_t        state;

   assign opcode       = instruction[INSTR_W-1 -: OPC_W];
   assign instr_unused = ^instruction[INSTR_W-OPC_W-1:0];
   assign is_move      = (opcode == OPC_W'(OP_MOVE));
   assign is_load      = (opcode == OPC_W'(OP_LOAD));
   assign instr_ready  = (state == IDLE);
   assign accept       = instr_valid && instr_ready;

`ifdef Z0_HUB_ILLEGAL_TRAP_EN
   logic halted;
   logic illegal_q;

   always_comb begin
      state = ld_state;
      if (halted) state = HALT;
   end
   assign illegal_op = illegal_q;
`else
   assign state      = ld_state;
   assign illegal_op = 1'b0;
`endif

   z0_hub_load_ctrl #(
      .DATA_W (DATA_W)
   ) u_load_ctrl (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (accept && is_load),
      .addr          (mov_mar),
      .done          (ld_done),
      .data          (ld_data),
      .state         (ld_state),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data)
   );

   // accept and ld_done never coincide: ld_done needs a load in flight, accept needs IDLE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reg_x   <= '0;
         reg_y   <= '0;
         reg_mar <= '0;
         reg_mdr <= '0;
         pc      <= PC_RESET;
         commit  <= 1'b0;
`ifdef Z0_HUB_ILLEGAL_TRAP_EN
         halted    <= 1'b0;
         illegal_q <= 1'b0;
`endif
      end else begin
         commit <= 1'b0;
         if (accept) begin
            if (is_move) begin
               reg_x   <= mov_x;
               reg_y   <= mov_y;
               reg_mar <= mov_mar;
               reg_mdr <= mov_mdr;
               pc      <= pc + PC_W'(1);
               commit  <= 1'b1;
            end else if (is_load) begin
               reg_x   <= mov_x;
               reg_y   <= mov_y;
               reg_mar <= mov_mar;
            end else begin
`ifdef Z0_HUB_ILLEGAL_TRAP_EN
               halted    <= 1'b1;
               illegal_q <= 1'b1;
`else
               pc     <= pc + PC_W'(1);
               commit <= 1'b1;
`endif
            end
         end
         if (ld_done) begin
            reg_mdr <= ld_data;
            pc      <= pc + PC_W'(1);
            commit  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_z0_commit_hub.sv
// Scoreboard bench for z0_commit_hub: stimulus pushes expected retire state, a negedge
// monitor pops it on every commit pulse. A second instance covers PC wrap.
module tb_z0_commit_hub;
   import z0_cpu_pkg::*;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] mar;
      logic [15:0] mdr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instruction = '0;
   logic [15:0] mov_x = '0, mov_y = '0, mov_mar = '0, mov_mdr = '0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [15:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [15:0] mem_rsp_data = '0;
   logic [15:0] reg_x, reg_y, reg_mar, reg_mdr, pc;
   logic        commit, illegal_op;

   logic        w_valid = 1'b0;
   logic        w_ready, w_req_valid, w_commit, w_illegal;
   logic [15:0] w_req_addr, w_x, w_y, w_mar, w_mdr, w_pc;
   logic        w_zero = 1'b0;
   logic [15:0] w_zdata = '0;

   int checks = 0;
   int errors = 0;
   exp_t q[$];
   logic [15:0] m_pc, m_x, m_y, m_mar, m_mdr;

   always #5 clk = ~clk;

   z0_commit_hub #(.PC_RESET(16'h0100)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instruction(instruction), .mov_x(mov_x), .mov_y(mov_y), .mov_mar(mov_mar),
      .mov_mdr(mov_mdr), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data), .reg_x(reg_x), .reg_y(reg_y), .reg_mar(reg_mar),
      .reg_mdr(reg_mdr), .pc(pc), .commit(commit), .illegal_op(illegal_op)
   );

   z0_commit_hub #(.PC_RESET(16'hFFFF)) u_wrap (
      .clk(clk), .rst_n(rst_n), .instr_valid(w_valid), .instr_ready(w_ready),
      .instruction(instruction), .mov_x(mov_x), .mov_y(mov_y), .mov_mar(mov_mar),
      .mov_mdr(mov_mdr), .mem_req_valid(w_req_valid), .mem_req_ready(w_zero),
      .mem_req_addr(w_req_addr), .mem_rsp_valid(w_zero), .mem_rsp_data(w_zdata),
      .reg_x(w_x), .reg_y(w_y), .reg_mar(w_mar), .reg_mdr(w_mdr), .pc(w_pc),
      .commit(w_commit), .illegal_op(w_illegal)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.pc = m_pc; e.x = m_x; e.y = m_y; e.mar = m_mar; e.mdr = m_mdr;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && commit) begin
         exp_t e, a;
         checks++;
         a.pc = pc; a.x = reg_x; a.y = reg_y; a.mar = reg_mar; a.mdr = reg_mdr;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_commit: got pc=%h mdr=%h expected no commit", pc, reg_mdr);
         end else begin
            e = q.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL commit_state: got pc=%h x=%h y=%h mar=%h mdr=%h expected pc=%h x=%h y=%h mar=%h mdr=%h",
                        a.pc, a.x, a.y, a.mar, a.mdr, e.pc, e.x, e.y, e.mar, e.mdr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!instr_ready && n < 20) begin
         tick();
         n++;
      end
      if (!instr_ready) begin
         errors++;
         $display("FAIL ready_timeout: got instr_ready=0 expected 1");
      end
   endtask

   // presents one instruction and leaves instr_valid high so MOVEs can run back-to-back
   task automatic issue(input logic [7:0] opc, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] mar, input logic [15:0] mdr);
      wait_ready();
      instruction = {opc, 8'h5A};
      mov_x = x; mov_y = y; mov_mar = mar; mov_mdr = mdr;
      instr_valid = 1'b1;
      tick();
   endtask

   task automatic model_reset();
      m_pc = 16'h0100; m_x = '0; m_y = '0; m_mar = '0; m_mdr = '0;
   endtask

   initial begin
      model_reset();
      // 1: reset held two cycles with inputs active
      rst_n = 1'b0;
      instr_valid = 1'b1; instruction = {OP_MOVE, 8'h00}; mov_x = 16'h7777;
      tick(); tick();
      instr_valid = 1'b0;
      rst_n = 1'b1;
      check("rst_pc", pc, 16'h0100);
      check("rst_regs", {reg_x, reg_y}, 32'h0);
      check("rst_regs2", {reg_mar, reg_mdr}, 32'h0);
      check("rst_ready", instr_ready, 1);
      check("rst_commit", commit, 0);
      check("rst_req", {mem_req_valid, illegal_op}, 0);
      check("rst_req_addr", mem_req_addr, 0);

      // 2: back-to-back MOVEs
      for (int i = 1; i <= 3; i++) begin
         m_x = 16'(i); m_y = 16'(i + 16'h10); m_mar = 16'(i + 16'h20); m_mdr = 16'(i + 16'h30);
         m_pc = m_pc + 16'd1;
         push_exp();
         issue(OP_MOVE, m_x, m_y, m_mar, m_mdr);
         check("b2b_ready", instr_ready, 1);
      end
      instr_valid = 1'b0;
      tick();
      check("b2b_pc", pc, 16'h0103);
      check("b2b_drain", q.size(), 0);

      // 3: LOAD, request accepted after 2 cycles, response 3 cycles later
      m_x = 16'h0A01; m_y = 16'h0A02; m_mar = 16'h00A0;
      issue(OP_LOAD, m_x, m_y, m_mar, 16'hDEAD);
      instr_valid = 1'b0;
      mov_x = 16'hFFFF; mov_mar = 16'h1111; mov_mdr = 16'h2222;
      for (int i = 0; i < 2; i++) begin
         check("ld_req_valid", mem_req_valid, 1);
         check("ld_req_addr", mem_req_addr, 16'h00A0);
         check("ld_busy_ready", instr_ready, 0);
         tick();
      end
      mem_req_ready = 1'b1;
      check("ld_req_addr_hs", mem_req_addr, 16'h00A0);
      tick();
      mem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("ld_wait_ready", instr_ready, 0);
         check("ld_wait_req", mem_req_valid, 0);
         tick();
      end
      check("ld_regs_early", {reg_x, reg_mar}, {16'h0A01, 16'h00A0});
      m_mdr = 16'hBEEF; m_pc = m_pc + 16'd1;
      push_exp();
      mem_rsp_valid = 1'b1; mem_rsp_data = 16'hBEEF;
      tick();
      mem_rsp_valid = 1'b0;
      tick();
      check("ld_done_ready", instr_ready, 1);
      check("ld_drain", q.size(), 0);

      // 4: request accept and response in the same cycle
      m_x = 16'h0B01; m_y = 16'h0B02; m_mar = 16'h00B0;
      issue(OP_LOAD, m_x, m_y, m_mar, 16'h0);
      instr_valid = 1'b0;
      check("fast_req_addr", mem_req_addr, 16'h00B0);
      m_mdr = 16'h1234; m_pc = m_pc + 16'd1;
      push_exp();
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 16'h1234;
      tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      check("fast_idle", instr_ready, 1);
      check("fast_req_drop", mem_req_valid, 0);
      tick();

      // 5: stray response in IDLE is ignored
      mem_rsp_valid = 1'b1; mem_rsp_data = 16'h5555;
      tick(); tick();
      mem_rsp_valid = 1'b0;
      check("stray_mdr", reg_mdr, 16'h1234);
      check("stray_pc", pc, m_pc);

      // 5b: PC wrap on the second instance
      check("wrap_pc_rst", w_pc, 16'hFFFF);
      instruction = {OP_MOVE, 8'h00}; mov_x = 16'h00C1;
      w_valid = 1'b1;
      tick();
      w_valid = 1'b0;
      check("wrap_pc", w_pc, 16'h0000);
      check("wrap_commit", w_commit, 1);
      check("wrap_x", w_x, 16'h00C1);

      // 6: reset during LOAD_WAIT abandons the load
      issue(OP_LOAD, 16'h0D01, 16'h0D02, 16'h00D0, 16'h0);
      instr_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      check("rwait_busy", instr_ready, 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      model_reset();
      mem_rsp_valid = 1'b1; mem_rsp_data = 16'hDEAD;
      tick();
      mem_rsp_valid = 1'b0;
      tick();
      check("rwait_mdr", reg_mdr, 16'h0000);
      check("rwait_pc", pc, 16'h0100);
      check("rwait_ready", instr_ready, 1);
      check("rwait_req", mem_req_valid, 0);

      // 6b: unknown opcode
      m_x = 16'h0E01;
      issue(OP_MOVE, m_x, 16'h0, 16'h0, 16'h0);
      m_pc = m_pc + 16'd1;
      q.push_front('0);
      void'(q.pop_front());
      push_exp();
      instr_valid = 1'b0;
      tick();
`ifdef Z0_HUB_ILLEGAL_TRAP_EN
      issue(8'h7F, 16'h9999, 16'h9999, 16'h9999, 16'h9999);
      instr_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("trap_ready", instr_ready, 0);
         check("trap_flag", illegal_op, 1);
         check("trap_pc", pc, m_pc);
         tick();
      end
`else
      m_pc = m_pc + 16'd1;
      push_exp();
      issue(8'h7F, 16'h9999, 16'h9999, 16'h9999, 16'h9999);
      instr_valid = 1'b0;
      tick();
      check("nop_pc", pc, m_pc);
      check("nop_x", reg_x, 16'h0E01);
      check("nop_flag", illegal_op, 0);
      check("nop_ready", instr_ready, 1);
`endif
      tick(); tick();
      check("final_drain", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
